dm_bridge: RTL and testbench
============================

DM_BRIDGE -- requirements
Module: dm_bridge

Interface
REQ-001 Parameter DM_WORDS, default 4096, data RAM depth in 32-bit words, power of two.
REQ-002 Parameter TIMER_BASE, default 32'h0000_7F00, base address of the timer register window.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  1  access request from the EX-stage initiator this cycle.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_byte / req_half  input  1 each  byte or halfword store size; both 0 = word store.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 rsp_rdata  output  32  registered read word, valid the cycle after the request.
REQ-011 rsp_err  output  1  registered one-cycle flag: unmapped or misaligned access.
REQ-012 irq  output  1  timer interrupt request, level.

Function
REQ-013 Decode: DM when req_addr < DM_WORDS*4; timer when req_addr is in TIMER_BASE..TIMER_BASE+0xB; otherwise unmapped.
REQ-014 Reads SHALL have 1-cycle latency; rsp_rdata is the full aligned word, and the initiator performs extension.
REQ-015 DM byte store SHALL write lane req_addr[1:0] with req_wdata[7:0]; half store writes lane req_addr[1] with [15:0]; word store writes all lanes.
REQ-016 Misaligned access (half with addr[0]=1; word with addr[1:0]!=0) SHALL suppress the write, return rdata 0, and set rsp_err next cycle.
REQ-017 Unmapped access SHALL return rdata 0, set rsp_err, and change no state.
REQ-018 A cycle with req_valid=0 SHALL leave rsp_rdata holding its prior value and set rsp_err=0.
REQ-019 A read of an address written in the previous cycle SHALL return the new data, with no stall.

Reset
REQ-020 On rst: rsp_rdata=0, rsp_err=0, irq=0, timer CTRL/PRESET/COUNT=0, timer FSM=IDLE.
REQ-021 DM contents SHALL NOT be reset.
REQ-022 rst asserted mid-count SHALL abort counting next edge, with no irq pulse.

Configuration
REQ-023 Macro DM_BRIDGE_TIMER_EN: when defined, the timer (REQ-024..REQ-030) is built; when undefined, the timer window decodes as unmapped and irq is tied 0.
REQ-024 Timer registers: CTRL at +0 (bit0 enable, bits[2:1] mode, bit3 irq mask), PRESET at +4, COUNT at +8 (read-only; writes are ignored without error). Timer accepts word accesses only; any other size sets rsp_err.
REQ-025 FSM states: IDLE, LOAD, CNT, INT.
REQ-026 IDLE->LOAD when CTRL.enable=1; LOAD copies PRESET into COUNT, then moves to CNT.
REQ-027 CNT decrements COUNT by 1 per cycle while enable=1 and COUNT>1; COUNT reaching 1 loads 0 and moves to INT.
REQ-028 INT, mode 0: clear enable, irq=CTRL.mask, return to IDLE. INT, mode 1: go to LOAD (auto-reload), with irq pulsed one cycle if masked-in.
REQ-029 Clearing enable in any state SHALL return the FSM to IDLE next cycle with COUNT frozen; mode-0 irq SHALL stay asserted until CTRL is written.
REQ-030 A CPU CTRL write in the same cycle as an FSM update SHALL win. A PRESET write during CNT SHALL take effect only at the next LOAD. PRESET=0 SHALL go LOAD->INT directly.

Structure
REQ-031 The shared package SHALL hold the timer state enum, the CTRL bit-index constants, and the register offsets (TMR_CTRL_OFF=0, TMR_PRESET_OFF=4, TMR_COUNT_OFF=8).
REQ-032 Sub-module dm_timer SHALL contain the register file and FSM; the address decode, DM array and response registers stay in dm_bridge.

Verification
REQ-033 Word write 0xDEADBEEF to 0x10, then read 0x10 -> rsp_rdata=0xDEADBEEF one cycle after the read, rsp_err=0.
REQ-034 Byte store 0xAA to 0x11 over that word, then read 0x10 -> 0xDEADAAEF; half store 0x1234 to 0x12 -> 0x1234AAEF.
REQ-035 Half store to 0x13 -> rsp_err=1 for exactly one cycle and the word is unchanged; read of 0x9000 -> rdata 0, rsp_err=1.
REQ-036 Write PRESET=3, then CTRL=0b1001 (mode 0, mask) -> COUNT reads 3,2,1,0, irq rises 1 cycle after INT and holds until CTRL is written.
REQ-037 Mode 1 with PRESET=2 -> periodic one-cycle irq pulses every 4 cycles. Asserting rst mid-count -> COUNT=0, irq=0, state IDLE; DM data is retained.
REQ-038 Build without DM_BRIDGE_TIMER_EN: read of TIMER_BASE -> rdata 0, rsp_err=1; irq stays 0.

Source files
------------

// File: rtl/dm_bridge_pkg.sv
// Shared types for dm_bridge: timer FSM states, CTRL bit positions, register offsets
// and the store lane-steering helpers used by the data RAM write path.
package dm_bridge_pkg;

    typedef enum logic [1:0] {
        TMR_IDLE = 2'd0,
        TMR_LOAD = 2'd1,
        TMR_CNT  = 2'd2,
        TMR_INT  = 2'd3
    } tmr_state_e;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_MASK_BIT = 3;

    localparam logic [3:0] TMR_CTRL_OFF   = 4'h0;
    localparam logic [3:0] TMR_PRESET_OFF = 4'h4;
    localparam logic [3:0] TMR_COUNT_OFF  = 4'h8;

    function automatic logic [3:0] lane_be(input logic is_byte, input logic is_half,
                                           input logic [1:0] a);
        if (is_byte) return 4'b0001 << a;
        if (is_half) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    // Replicate right-aligned store data onto every lane it could land in.
    function automatic logic [31:0] lane_data(input logic is_byte, input logic is_half,
                                              input logic [31:0] wdata);
        if (is_byte) return {4{wdata[7:0]}};
        if (is_half) return {2{wdata[15:0]}};
        return wdata;
    endfunction

endpackage

// File: rtl/dm_timer.sv
// Timer register file (CTRL/PRESET/COUNT) and IDLE/LOAD/CNT/INT sequencer.
// Register reads are combinational; writes land on the next edge; no backpressure.
// Built only when DM_BRIDGE_TIMER_EN is defined.
module dm_timer
    import dm_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  off,
    input  logic [31:0] wr_dat,
    output logic [31:0] rd_dat,
    output logic        irq
);

    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    tmr_state_e  state_q, state_d;
    logic        irq_q, irq_d;
    logic        en;
    logic [1:0]  mode;

    assign en   = ctrl_q[CTRL_EN_BIT];
    assign mode = ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB];
    assign irq  = irq_q;

    always_comb begin
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        state_d  = state_q;
        irq_d    = irq_q;
        if (state_q != TMR_IDLE && !en) begin
            state_d = TMR_IDLE;
        end else begin
            case (state_q)
                TMR_IDLE: if (en) state_d = TMR_LOAD;
                TMR_LOAD: begin
                    irq_d   = 1'b0;
                    count_d = preset_q;
                    state_d = (preset_q == 32'd0) ? TMR_INT : TMR_CNT;
                end
                TMR_CNT: begin
                    if (count_q > 32'd1) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        count_d = 32'd0;
                        state_d = TMR_INT;
                    end
                end
                TMR_INT: begin
                    irq_d = ctrl_q[CTRL_MASK_BIT];
                    if (mode == 2'd1) begin
                        state_d = TMR_LOAD;
                    end else begin
                        ctrl_d[CTRL_EN_BIT] = 1'b0;
                        state_d             = TMR_IDLE;
                    end
                end
                default: state_d = TMR_IDLE;
            endcase
        end
        // CPU writes override whatever the sequencer decided this cycle.
        if (wr_en) begin
            case (off)
                TMR_CTRL_OFF: begin
                    ctrl_d = wr_dat[3:0];
                    irq_d  = 1'b0;
                end
                TMR_PRESET_OFF: preset_d = wr_dat;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_dat = 32'd0;
        case (off)
            TMR_CTRL_OFF:   rd_dat = {28'd0, ctrl_q};
            TMR_PRESET_OFF: rd_dat = preset_q;
            TMR_COUNT_OFF:  rd_dat = count_q;
            default:        rd_dat = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            state_q  <= TMR_IDLE;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            state_q  <= state_d;
            irq_q    <= irq_d;
        end
    end

endmodule

// File: rtl/dm_bridge.sv
// Data-memory bridge: address decode, byte-lane DM array, optional timer (DM_BRIDGE_TIMER_EN).
// Latency: read data and error flag registered, valid one cycle after the request.
// Backpressure: none; every request is accepted in the cycle it is presented.
module dm_bridge
    import dm_bridge_pkg::*;
#(
    parameter int unsigned DM_WORDS   = 4096,
    parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic        req_half,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        irq
);

    localparam int         AW       = $clog2(DM_WORDS);
    localparam logic [32:0] DM_BYTES = 33'(DM_WORDS) << 2;

    logic [31:0] dm_mem [DM_WORDS];

    logic          dm_hit, misal, tmr_win, tmr_bad, acc_err, dm_we;
    logic [AW-1:0] dm_idx;
    logic [3:0]    dm_be;
    logic [31:0]   dm_wlanes;
    logic [31:0]   tmr_rdat;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    assign dm_hit = {1'b0, req_addr} < DM_BYTES;
    assign dm_idx = req_addr[AW+1:2];

`ifdef DM_BRIDGE_TIMER_EN
    logic [3:0] tmr_off;
    logic       tmr_wr_en;

    assign tmr_win   = (req_addr >= TIMER_BASE) && ((req_addr - TIMER_BASE) <= 32'hB);
    assign tmr_off   = 4'(req_addr - TIMER_BASE);
    assign tmr_wr_en = req_valid && req_we && !dm_hit && tmr_win && !tmr_bad;

    dm_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (tmr_wr_en),
        .off    (tmr_off),
        .wr_dat (req_wdata),
        .rd_dat (tmr_rdat),
        .irq    (irq)
    );
`else
    assign tmr_win  = 1'b0;
    assign tmr_rdat = 32'd0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        misal   = !req_byte && (req_half ? req_addr[0] : (req_addr[1:0] != 2'b00));
        tmr_bad = tmr_win && (req_byte || req_half || (req_addr[1:0] != 2'b00));
        // DM wins any overlap with the timer window.
        acc_err = dm_hit ? misal : (tmr_win ? tmr_bad : 1'b1);
        dm_we     = req_valid && req_we && dm_hit && !misal;
        dm_be     = lane_be(req_byte, req_half, req_addr[1:0]);
        dm_wlanes = lane_data(req_byte, req_half, req_wdata);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (dm_we && dm_be[i]) dm_mem[dm_idx][8*i +: 8] <= dm_wlanes[8*i +: 8];
        end
    end

    always_comb begin
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = 1'b0;
        if (req_valid) begin
            if (acc_err) begin
                rsp_rdata_d = 32'd0;
                rsp_err_d   = 1'b1;
            end else if (!req_we) begin
                rsp_rdata_d = dm_hit ? dm_mem[dm_idx] : tmr_rdat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dm_bridge.sv
// Bench for dm_bridge: directed vector table, randomized DM traffic against a word-array
// model, and hand-written timer sequences when DM_BRIDGE_TIMER_EN is defined.
`timescale 1ns/1ps
module tb_dm_bridge;

    localparam logic [31:0] TB = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_byte, req_half;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] rsp_rdata;
    logic        rsp_err, irq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dm_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_byte  (req_byte),
        .req_half  (req_half),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .irq       (irq)
    );

    typedef struct packed {
        logic        v, we, b, h;
        logic [31:0] a, wd, exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t        vt [22];
    logic [31:0] mem_m [64];
    logic [31:0] rd_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents one request for one cycle; returns 1ns after the edge that captured it.
    task automatic apply(input logic v, input logic we, input logic b, input logic h,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid = v;
        req_we    = we;
        req_byte  = b;
        req_half  = h;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        apply(1'b1, 1'b1, 1'b0, 1'b0, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        apply(1'b1, 1'b0, 1'b0, 1'b0, a, 32'd0);
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0; req_half = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("reset rdata", rsp_rdata, 32'd0);
        chk("reset err", 32'(rsp_err), 32'd0);
        chk("reset irq", 32'(irq), 32'd0);

        //           v     we    b     h     addr           wdata          exp_rd         err
        vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0011, 32'hFFFF_FFAA, 32'hDEAD_BEEF, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_AAEF, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0012, 32'hABCD_1234, 32'hDEAD_AAEF, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h1234_AAEF, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0013, 32'h0000_5555, 32'h0000_0000, 1'b1};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h1234_AAEF, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_9000, 32'h0,         32'h0000_0000, 1'b1};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0};
        vt[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0016, 32'h1234_5678, 32'h0000_0000, 1'b1};
        vt[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0014, 32'h1122_3344, 32'h0000_0000, 1'b0};
        vt[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0017, 32'h0000_0099, 32'h0000_0000, 1'b0};
        vt[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0014, 32'h0,         32'h9922_3344, 1'b0};
        vt[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_3FFC, 32'hCAFE_F00D, 32'h9922_3344, 1'b0};
        vt[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_4000, 32'h0000_0BAD, 32'h0000_0000, 1'b1};
        vt[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3FFC, 32'h0,         32'hCAFE_F00D, 1'b0};
        vt[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0012, 32'h0,         32'h1234_AAEF, 1'b0};
        vt[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'h1234_AAEF, 1'b0};
        vt[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0015, 32'h0,         32'h0000_0000, 1'b1};
        vt[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h5555_5555, 32'h0000_0000, 1'b0};

        for (int i = 0; i < 22; i++) begin
            apply(vt[i].v, vt[i].we, vt[i].b, vt[i].h, vt[i].a, vt[i].wd);
            chk($sformatf("vec%0d rdata", i), rsp_rdata, vt[i].exp_rd);
            chk($sformatf("vec%0d err", i), 32'(rsp_err), 32'(vt[i].exp_err));
        end

        // Random DM traffic over the first 64 words, plus occasional unmapped hits.
        rd_m = vt[21].exp_rd;
        for (int i = 0; i < 64; i++) begin
            mem_m[i] = $urandom();
            wr(32'(i * 4), mem_m[i]);
        end
        for (int i = 0; i < 500; i++) begin
            logic        v, we, b, h, ee;
            logic [31:0] a, wd, msk;
            int          sz, w, sh;
            v  = ($urandom_range(0, 4) != 0);
            we = 1'($urandom_range(0, 1));
            sz = $urandom_range(0, 2);
            b  = (sz == 0);
            h  = (sz == 1);
            wd = $urandom();
            if ($urandom_range(0, 9) == 0) a = 32'h0001_0000 + 32'($urandom_range(0, 255));
            else                           a = 32'($urandom_range(0, 255));
            ee = 1'b0;
            if (v) begin
                if (a >= 32'h4000 || (h && a[0]) || (!b && !h && a[1:0] != 2'b00)) begin
                    ee   = 1'b1;
                    rd_m = 32'd0;
                end else begin
                    w = int'(a >> 2);
                    if (!we) begin
                        rd_m = mem_m[w];
                    end else begin
                        if (b)      begin sh = 8 * int'(a[1:0]);  msk = 32'hFF << sh; end
                        else if (h) begin sh = 16 * int'(a[1]);   msk = 32'hFFFF << sh; end
                        else        begin sh = 0;                 msk = 32'hFFFF_FFFF; end
                        mem_m[w] = (mem_m[w] & ~msk) | ((wd << sh) & msk);
                    end
                end
            end
            apply(v, we, b, h, a, wd);
            chk($sformatf("rand%0d rdata", i), rsp_rdata, rd_m);
            chk($sformatf("rand%0d err", i), 32'(rsp_err), 32'(ee));
            chk($sformatf("rand%0d irq", i), 32'(irq), 32'd0);
        end

`ifdef DM_BRIDGE_TIMER_EN
        begin
            logic [31:0] exp_cnt [8];
            logic        exp_irq [8];
            logic        want;
            exp_cnt = '{32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
            exp_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
            // One-shot, masked-in, PRESET=3.
            wr(TB + 32'h4, 32'd3);
            chk("preset wr err", 32'(rsp_err), 32'd0);
            wr(TB, 32'h9);
            for (int k = 0; k < 8; k++) begin
                rd(TB + 32'h8);
                chk($sformatf("oneshot count%0d", k), rsp_rdata, exp_cnt[k]);
                chk($sformatf("oneshot irq%0d", k), 32'(irq), 32'(exp_irq[k]));
            end
            rd(TB);
            chk("oneshot ctrl en cleared", rsp_rdata, 32'h8);
            chk("oneshot irq held", 32'(irq), 32'd1);
            wr(TB, 32'h0);
            chk("irq cleared by ctrl wr", 32'(irq), 32'd0);

            // PRESET=0 goes straight from LOAD to INT.
            wr(TB + 32'h4, 32'd0);
            wr(TB, 32'h9);
            idle(); chk("p0 irq e1", 32'(irq), 32'd0);
            idle(); chk("p0 irq e2", 32'(irq), 32'd0);
            idle(); chk("p0 irq e3", 32'(irq), 32'd1);
            wr(TB, 32'h0);

            // Disabling mid-count freezes COUNT; COUNT is read-only; bad size errors.
            wr(TB + 32'h4, 32'd10);
            wr(TB, 32'h1);
            for (int k = 0; k < 4; k++) idle();
            wr(TB, 32'h0);
            rd(TB + 32'h8); chk("freeze count a", rsp_rdata, 32'd7);
            rd(TB + 32'h8); chk("freeze count b", rsp_rdata, 32'd7);
            wr(TB + 32'h8, 32'h55);
            chk("count wr no err", 32'(rsp_err), 32'd0);
            rd(TB + 32'h8); chk("count wr ignored", rsp_rdata, 32'd7);
            apply(1'b1, 1'b1, 1'b1, 1'b0, TB, 32'h1);
            chk("tmr byte err", 32'(rsp_err), 32'd1);
            rd(TB); chk("tmr byte no write", rsp_rdata, 32'd0);

            // PRESET rewritten during CNT must not disturb the running count.
            wr(TB + 32'h4, 32'd4);
            wr(TB, 32'h1);
            idle(); idle();
            wr(TB + 32'h4, 32'd1);
            rd(TB + 32'h8); chk("preset in cnt a", rsp_rdata, 32'd3);
            rd(TB + 32'h8); chk("preset in cnt b", rsp_rdata, 32'd2);
            wr(TB, 32'h0);

            // Auto-reload, PRESET=2: first pulse 5 cycles after enable, then every 4.
            wr(TB + 32'h4, 32'd2);
            wr(TB, 32'hB);
            for (int k = 1; k <= 14; k++) begin
                idle();
                want = (k >= 5) && ((k - 5) % 4 == 0);
                chk($sformatf("reload irq%0d", k), 32'(irq), 32'(want));
            end
        end
`else
        rd(TB);
        chk("no-timer rd rdata", rsp_rdata, 32'd0);
        chk("no-timer rd err", 32'(rsp_err), 32'd1);
        wr(TB, 32'h9);
        chk("no-timer wr err", 32'(rsp_err), 32'd1);
        for (int k = 0; k < 6; k++) begin
            idle();
            chk($sformatf("no-timer irq%0d", k), 32'(irq), 32'd0);
        end
`endif

        rd(32'h0000_3FFC);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("rst rdata", rsp_rdata, 32'd0);
        chk("rst err", 32'(rsp_err), 32'd0);
        chk("rst irq", 32'(irq), 32'd0);
`ifdef DM_BRIDGE_TIMER_EN
        rd(TB + 32'h8); chk("rst count", rsp_rdata, 32'd0);
        rd(TB);         chk("rst ctrl", rsp_rdata, 32'd0);
        for (int k = 0; k < 6; k++) begin
            idle();
            chk($sformatf("rst idle irq%0d", k), 32'(irq), 32'd0);
        end
        rd(TB + 32'h8); chk("rst count idle", rsp_rdata, 32'd0);
`endif
        rd(32'h0000_3FFC); chk("dm kept 3ffc", rsp_rdata, 32'hCAFE_F00D);
        rd(32'h0000_0010); chk("dm kept 10", rsp_rdata, mem_m[4]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
